// File: rtl/fir_pkg.sv
// Shared types and constants for the 3x3 FIR frame sequencing controller.
package fir_pkg;

  localparam int unsigned MAX_WIDTH_DEF = 2048;
  localparam int unsigned COEF_W        = 3;

  // Controller states: waiting for a first frame, measuring geometry, locked.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Bit positions inside border_o = {top, bottom, left, right}.
  localparam int unsigned BRD_TOP    = 3;
  localparam int unsigned BRD_BOTTOM = 2;
  localparam int unsigned BRD_LEFT   = 1;
  localparam int unsigned BRD_RIGHT  = 0;

  // Preset 0 is the identity kernel used until the first lock.
  localparam logic [COEF_W-1:0] COEF_IDENTITY = 3'd0;

  // Video timing strobes travelling together through the one-cycle delay.
  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } timing_t;

endpackage

// File: rtl/fir_frame_ctrl_if.sv
// Video timing in, sequencing/control out, between rgb2y and the FIR datapath.
interface fir_frame_ctrl_if
  import fir_pkg::*;
#(
  parameter int unsigned AW = 11
) ();

  logic              dv_i;
  logic              hs_i;
  logic              vs_i;
  logic [COEF_W-1:0] coef_sel_i;

  logic              dv_o;
  logic              hs_o;
  logic              vs_o;
  logic [AW-1:0]     col_o;
  logic [AW-1:0]     row_o;
  logic [AW-1:0]     lb_addr_o;
  logic              lb_we_o;
  logic [3:0]        border_o;
  logic [COEF_W-1:0] coef_sel_o;
  logic [AW-1:0]     frame_w_o;
  logic [AW-1:0]     frame_h_o;
  logic              locked_o;
  logic              err_o;

  modport master (
    output dv_i, hs_i, vs_i, coef_sel_i,
    input  dv_o, hs_o, vs_o, col_o, row_o, lb_addr_o, lb_we_o, border_o,
           coef_sel_o, frame_w_o, frame_h_o, locked_o, err_o
  );

  modport slave (
    input  dv_i, hs_i, vs_i, coef_sel_i,
    output dv_o, hs_o, vs_o, col_o, row_o, lb_addr_o, lb_we_o, border_o,
           coef_sel_o, frame_w_o, frame_h_o, locked_o, err_o
  );

endinterface

// File: rtl/fir_frame_ctrl_sync_2ff.sv
// Two-flop synchronizer for slow, frame-asynchronous control bits.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops; the first may go metastable, the second settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencing for the 3x3 FIR: pixel position, geometry lock,
// line-buffer control, border flags and frame-aligned preset switching.
module fir_frame_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
  parameter int unsigned AW        = $clog2(MAX_WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  fir_frame_ctrl_if.slave bus
);

  localparam logic [AW-1:0] COL_MAX = AW'(MAX_WIDTH - 1);

  timing_t           tim_q, tim_n;
  state_e            state_q, state_n;
  logic [AW-1:0]     col_cnt_q, col_cnt_n;
  logic [AW-1:0]     row_cnt_q, row_cnt_n;
  logic [AW-1:0]     w_cur_q, w_cur_n;
  logic [AW-1:0]     fw_q, fw_n;
  logic [AW-1:0]     fh_q, fh_n;
  logic [AW-1:0]     col_q, row_q;
  logic [AW-1:0]     pix_col, pix_row;
  logic              full_q, full_n;
  logic              err_q, err_n;
  logic              fs, le, match, fs_q;
  logic [3:0]        border_q, border_n;
  logic              we_q, we_n;
  logic              locked_q;
  logic [COEF_W-1:0] coef_sync, coef_q, coef_n;

  sync_2ff #(.W(COEF_W)) u_coef_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.coef_sel_i),
    .q     (coef_sync)
  );

  // Event detection, counters, geometry tracking, FSM next state and outputs.
  always_comb begin
    tim_n     = '{dv: bus.dv_i, hs: bus.hs_i, vs: bus.vs_i};
    fs        = bus.vs_i & ~tim_q.vs;
    le        = tim_q.dv & ~bus.dv_i;
    // A frame start wins over everything: the coincident pixel is (0,0).
    pix_col   = fs ? '0 : col_cnt_q;
    pix_row   = fs ? '0 : row_cnt_q;
    col_cnt_n = pix_col;
    full_n    = full_q & ~fs;
    // full_q marks that column MAX_WIDTH-1 was already used in this line.
    err_n     = ~fs & (err_q | (bus.dv_i & full_q));
    if (bus.dv_i) begin
      if (pix_col == COL_MAX) begin
        full_n = 1'b1;
      end else begin
        col_cnt_n = pix_col + AW'(1);
      end
    end else if (le) begin
      col_cnt_n = '0;
      full_n    = 1'b0;
    end
    row_cnt_n = fs ? '0 : (le ? row_cnt_q + AW'(1) : row_cnt_q);
    // A full MAX_WIDTH line wraps to 0, which still decodes right at MAX_WIDTH-1.
    w_cur_n   = le ? col_q + AW'(1) : w_cur_q;
    fw_n      = fs ? w_cur_q   : fw_q;
    fh_n      = fs ? row_cnt_q : fh_q;
    match     = ~err_q & (w_cur_q == fw_q) & (row_cnt_q == fh_q);

    state_n = state_q;
    case (state_q)
      ST_IDLE:    if (fs)           state_n = ST_MEASURE;
      ST_MEASURE: if (fs && match)  state_n = ST_RUN;
      ST_RUN:     if (fs && !match) state_n = ST_MEASURE;
      default:                      state_n = ST_IDLE;
    endcase

    border_n = '0;
    if (bus.dv_i) begin
      border_n[BRD_TOP]    = (pix_row == '0);
      border_n[BRD_BOTTOM] = (state_n == ST_RUN) && (pix_row == fh_n - AW'(1));
      border_n[BRD_LEFT]   = (pix_col == '0);
      border_n[BRD_RIGHT]  = (state_n == ST_RUN) && (pix_col == fw_n - AW'(1));
    end
    we_n = bus.dv_i & ~err_n & (state_n != ST_IDLE);

    // Preset swaps the cycle after a frame start that left the FSM in RUN.
    coef_n = (fs_q && (state_q == ST_RUN)) ? coef_sync : coef_q;
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_q     <= '0;
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      w_cur_q   <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      fs_q      <= 1'b0;
      border_q  <= '0;
      we_q      <= 1'b0;
      locked_q  <= 1'b0;
      coef_q    <= COEF_IDENTITY;
    end else begin
      tim_q     <= tim_n;
      state_q   <= state_n;
      col_cnt_q <= col_cnt_n;
      row_cnt_q <= row_cnt_n;
      w_cur_q   <= w_cur_n;
      fw_q      <= fw_n;
      fh_q      <= fh_n;
      col_q     <= pix_col;
      row_q     <= pix_row;
      full_q    <= full_n;
      err_q     <= err_n;
      fs_q      <= fs;
      border_q  <= border_n;
      we_q      <= we_n;
      locked_q  <= (state_n == ST_RUN);
      coef_q    <= coef_n;
    end
  end

  assign bus.dv_o       = tim_q.dv;
  assign bus.hs_o       = tim_q.hs;
  assign bus.vs_o       = tim_q.vs;
  assign bus.col_o      = col_q;
  assign bus.row_o      = row_q;
  assign bus.lb_addr_o  = col_q;
  assign bus.lb_we_o    = we_q;
  assign bus.border_o   = border_q;
  assign bus.coef_sel_o = coef_q;
  assign bus.frame_w_o  = fw_q;
  assign bus.frame_h_o  = fh_q;
  assign bus.locked_o   = locked_q;
  assign bus.err_o      = err_q;

endmodule
